// File: rtl/hwpf_stride_cfg_prog_pkg.sv
// Shared types and sizes for the stride prefetcher configuration front end.
// HWPF_STRIDE_CFG_READBACK_EN (top level) enables readback of stored cfg registers.
package hwpf_stride_cfg_prog_pkg;

  localparam int unsigned NUM_HW_PREFETCH   = 4;
  localparam int unsigned ADDR_W            = 6;
  localparam int unsigned DATA_W            = 64;
  localparam int unsigned ENG_W             = ADDR_W - 2;
  localparam int unsigned STATUS_ENGINE_IDX = NUM_HW_PREFETCH;

  typedef enum logic [1:0] {
    REG_BASE     = 2'd0,
    REG_PARAM    = 2'd1,
    REG_THROTTLE = 2'd2,
    REG_RSVD     = 2'd3
  } reg_idx_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WR_STROBE = 2'd1,
    ST_RESP      = 2'd2
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] base;
    logic [DATA_W-1:0] param;
    logic [DATA_W-1:0] throttle;
  } hwpf_cfg_regs_t;

endpackage

// File: rtl/hwpf_stride_cfg_prog_decode.sv
// Combinational word-address decode: engine one-hot, register index, status select, error.
module hwpf_stride_cfg_prog_decode
  import hwpf_stride_cfg_prog_pkg::*;
(
  input  logic [ADDR_W-1:0]          addr,
  input  logic                       we,
  output logic [NUM_HW_PREFETCH-1:0] eng_oh_c,
  output reg_idx_e                   reg_idx_c,
  output logic                       is_status_c,
  output logic                       err_c
);

  logic [ENG_W-1:0] eng;

  assign eng       = addr[ADDR_W-1:2];
  assign reg_idx_c = reg_idx_e'(addr[1:0]);

  // Upper engine-field values beyond the status slot are rejected, so stray high bits error out.
  always_comb begin
    eng_oh_c    = '0;
    is_status_c = 1'b0;
    err_c       = 1'b0;
    if (eng < ENG_W'(NUM_HW_PREFETCH)) begin
      if (reg_idx_c == REG_RSVD) begin
        err_c = 1'b1;
      end else begin
        for (int unsigned e = 0; e < NUM_HW_PREFETCH; e++) begin
          if (eng == ENG_W'(e)) eng_oh_c[e] = 1'b1;
        end
      end
    end else if ((eng == ENG_W'(STATUS_ENGINE_IDX)) && (reg_idx_c == REG_BASE)) begin
      if (we) err_c = 1'b1;
      else    is_status_c = 1'b1;
    end else begin
      err_c = 1'b1;
    end
  end

endmodule

// File: rtl/hwpf_stride_cfg_prog.sv
// CSR front end programming per-engine stride prefetcher cfg with set strobes and status readback.
// Optional: HWPF_STRIDE_CFG_READBACK_EN returns stored base/param/throttle on reads (else 0).
module hwpf_stride_cfg_prog
  import hwpf_stride_cfg_prog_pkg::*;
(
  input  logic                                        clk_i,
  input  logic                                        rst_i,
  input  logic                                        req_valid_i,
  output logic                                        req_ready_o,
  input  logic                                        req_we_i,
  input  logic [ADDR_W-1:0]                           req_addr_i,
  input  logic [DATA_W-1:0]                           req_wdata_i,
  output logic                                        rsp_valid_o,
  input  logic                                        rsp_ready_i,
  output logic [DATA_W-1:0]                           rsp_rdata_o,
  output logic                                        rsp_err_o,
  output logic [NUM_HW_PREFETCH-1:0]                  base_set_o,
  output logic [NUM_HW_PREFETCH-1:0]                  param_set_o,
  output logic [NUM_HW_PREFETCH-1:0]                  throttle_set_o,
  output hwpf_cfg_regs_t [NUM_HW_PREFETCH-1:0]        cfg_o,
  input  logic [DATA_W-1:0]                           status_i
);

  state_e                     state_q;
  logic [NUM_HW_PREFETCH-1:0] eng_oh_c;
  reg_idx_e                   reg_idx_c;
  logic                       is_status_c;
  logic                       err_c;
  logic                       accept_c;
  logic [DATA_W-1:0]          rd_data_c;

  hwpf_stride_cfg_prog_decode u_decode (
    .addr        (req_addr_i),
    .we          (req_we_i),
    .eng_oh_c    (eng_oh_c),
    .reg_idx_c   (reg_idx_c),
    .is_status_c (is_status_c),
    .err_c       (err_c)
  );

  assign accept_c = req_valid_i & req_ready_o;

  // Read data mux; status is sampled in the accept cycle.
  always_comb begin
    rd_data_c = '0;
    if (is_status_c) begin
      rd_data_c = status_i;
    end
`ifdef HWPF_STRIDE_CFG_READBACK_EN
    else begin
      for (int unsigned e = 0; e < NUM_HW_PREFETCH; e++) begin
        if (eng_oh_c[e]) begin
          case (reg_idx_c)
            REG_BASE:     rd_data_c = cfg_o[e].base;
            REG_PARAM:    rd_data_c = cfg_o[e].param;
            REG_THROTTLE: rd_data_c = cfg_o[e].throttle;
            default:      rd_data_c = '0;
          endcase
        end
      end
    end
`endif
  end

  // Request/response FSM; cfg registers and strobes are written from the accept cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= ST_IDLE;
      req_ready_o    <= 1'b0;
      rsp_valid_o    <= 1'b0;
      rsp_rdata_o    <= '0;
      rsp_err_o      <= 1'b0;
      base_set_o     <= '0;
      param_set_o    <= '0;
      throttle_set_o <= '0;
      cfg_o          <= '0;
    end else begin
      base_set_o     <= '0;
      param_set_o    <= '0;
      throttle_set_o <= '0;
      case (state_q)
        ST_IDLE: begin
          req_ready_o <= 1'b1;
          if (accept_c) begin
            req_ready_o <= 1'b0;
            if (req_we_i && !err_c) begin
              for (int unsigned e = 0; e < NUM_HW_PREFETCH; e++) begin
                if (eng_oh_c[e]) begin
                  case (reg_idx_c)
                    REG_BASE: begin
                      cfg_o[e].base <= req_wdata_i;
                      base_set_o[e] <= 1'b1;
                    end
                    REG_PARAM: begin
                      cfg_o[e].param <= req_wdata_i;
                      param_set_o[e] <= 1'b1;
                    end
                    REG_THROTTLE: begin
                      cfg_o[e].throttle <= req_wdata_i;
                      throttle_set_o[e] <= 1'b1;
                    end
                    default: ;
                  endcase
                end
              end
              state_q <= ST_WR_STROBE;
            end else begin
              rsp_valid_o <= 1'b1;
              rsp_err_o   <= err_c;
              rsp_rdata_o <= (req_we_i || err_c) ? '0 : rd_data_c;
              state_q     <= ST_RESP;
            end
          end
        end
        ST_WR_STROBE: begin
          rsp_valid_o <= 1'b1;
          rsp_err_o   <= 1'b0;
          rsp_rdata_o <= '0;
          state_q     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            rsp_err_o   <= 1'b0;
            rsp_rdata_o <= '0;
            req_ready_o <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          req_ready_o <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
